// File: rtl/dibit_pack.sv
// rtl/dibit_pack.sv - packs four 2-bit slices into an 8-bit word with first-slot resync and output backpressure
module dibit_pack #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] din,
  input  logic       din_valid,
  input  logic       din_first,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [1:0] slot,
  output logic       sync_err,
  output logic [7:0] word_cnt
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t     state;
  logic [7:0] staging;
  logic [7:0] stage_next;
  logic [1:0] eff_slot;
  logic       accept;
  logic       transfer;
  logic       resync;
  logic       complete;
  logic       blocked;

  function automatic logic [2:0] slot_pos(input logic [1:0] k);
    if (LSB_FIRST != 0) return {k, 1'b0};
    else                return 3'd6 - {k, 1'b0};
  endfunction

  always_comb begin
    din_ready  = (state == FILL) && ((slot != 2'd3) || !dout_valid || dout_ready);
    accept     = din_valid && din_ready;
    transfer   = dout_valid && dout_ready;
    resync     = din_first && (slot != 2'd0);
    // A misplaced first slice restarts the word from slot 0
    eff_slot   = resync ? 2'd0 : slot;
    stage_next = resync ? 8'h00 : staging;
    stage_next[slot_pos(eff_slot) +: 2] = din;
    complete   = accept && (eff_slot == 2'd3);
    blocked    = dout_valid && !dout_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      slot       <= 2'd0;
      staging    <= 8'h00;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
      word_cnt   <= 8'h00;
    end else begin
      sync_err <= accept && resync;
      if (transfer) word_cnt <= word_cnt + 8'd1;
      case (state)
        FILL: begin
          if (accept) begin
            staging <= stage_next;
            // Completed word with the output still occupied parks in staging
            if (complete && blocked) begin
              state <= HOLD;
              slot  <= 2'd3;
            end else begin
              slot <= eff_slot + 2'd1;
            end
          end
          if (complete && !blocked) begin
            dout       <= stage_next;
            dout_valid <= 1'b1;
          end else if (transfer) begin
            dout_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (transfer) begin
            dout       <= staging;
            dout_valid <= 1'b1;
            slot       <= 2'd0;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_dibit_pack.sv
// tb/tb_dibit_pack.sv - directed vector bench for dibit_pack (both slot orders)
module tb_dibit_pack;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] din = 2'd0;
  logic       din_valid = 1'b0;
  logic       din_first = 1'b0;
  logic       dout_ready = 1'b0;

  logic       din_ready, dout_valid, sync_err;
  logic [7:0] dout, word_cnt;
  logic [1:0] slot;
  logic       din_ready_m, dout_valid_m, sync_err_m;
  logic [7:0] dout_m, word_cnt_m;
  logic [1:0] slot_m;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dibit_pack #(.LSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_first(din_first),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .slot(slot), .sync_err(sync_err), .word_cnt(word_cnt)
  );

  dibit_pack #(.LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_first(din_first),
    .din_ready(din_ready_m), .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
    .slot(slot_m), .sync_err(sync_err_m), .word_cnt(word_cnt_m)
  );

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       f;
    logic       r;
    logic       rdy;
    logic       dv;
    logic [7:0] dout;
    logic [1:0] slot;
    logic       serr;
    logic [7:0] wc;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic f, input logic r);
    @(negedge clk);
    din_valid  = v;
    din        = d;
    din_first  = f;
    dout_ready = r;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_dout"}, dout, 8'h00);
    chk({tag, "_dv"}, dout_valid, 1'b0);
    chk({tag, "_slot"}, slot, 2'd0);
    chk({tag, "_serr"}, sync_err, 1'b0);
    chk({tag, "_wc"}, word_cnt, 8'h00);
    chk({tag, "_rdy"}, din_ready, 1'b1);
  endtask

  initial begin
    // 67 streamed, then 67/A5 under backpressure, then resync into 3C
    tbl[0]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd3, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h67, 2'd0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h67, 2'd0, 1'b0, 8'd1};
    tbl[5]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h67, 2'd1, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h67, 2'd2, 1'b0, 8'd1};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h67, 2'd3, 1'b0, 8'd1};
    tbl[8]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h67, 2'd0, 1'b0, 8'd1};
    tbl[9]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h67, 2'd1, 1'b0, 8'd1};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h67, 2'd2, 1'b0, 8'd1};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h67, 2'd3, 1'b0, 8'd1};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h67, 2'd3, 1'b0, 8'd1};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h67, 2'd3, 1'b0, 8'd1};
    tbl[14] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd0, 1'b0, 8'd2};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 2'd0, 1'b0, 8'd3};
    tbl[16] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 2'd1, 1'b0, 8'd3};
    tbl[17] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 2'd2, 1'b0, 8'd3};
    tbl[18] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 2'd1, 1'b1, 8'd3};
    tbl[19] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 2'd2, 1'b0, 8'd3};
    tbl[20] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 2'd3, 1'b0, 8'd3};
    tbl[21] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 2'd0, 1'b0, 8'd3};
    tbl[22] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 2'd0, 1'b0, 8'd4};
    tbl[23] = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 2'd0, 1'b0, 8'd4};

    #12;
    check_reset("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      #1;
      chk($sformatf("v%0d_rdy", i), din_ready, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_dv", i), dout_valid, tbl[i].dv);
      chk($sformatf("v%0d_dout", i), dout, tbl[i].dout);
      chk($sformatf("v%0d_slot", i), slot, tbl[i].slot);
      chk($sformatf("v%0d_serr", i), sync_err, tbl[i].serr);
      chk($sformatf("v%0d_wc", i), word_cnt, tbl[i].wc);
    end

    // Held word plus a partial word, then asynchronous reset mid-cycle
    drive(1'b1, 2'd3, 1'b1, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b1, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_dv", dout_valid, 1'b1);
    chk("pre_rst_slot", slot, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst");
    chk("arst_dout_m", dout_m, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd3, 1'b1, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_dv", dout_valid, 1'b1);
    chk("post_rst_dout", dout, 8'h67);
    chk("msb_dout", dout_m, 8'hD9);
    chk("msb_dv", dout_valid_m, 1'b1);
    chk("post_rst_wc", word_cnt, 8'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("post_rst_wc1", word_cnt, 8'd1);
    chk("post_rst_dv0", dout_valid, 1'b0);

    // 256 back-to-back words, word i carries value i
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] w;
        w = 8'(i);
        drive(1'b1, w[2*k +: 2], (k == 0), 1'b1);
        #1;
        if (din_ready !== 1'b1) chk($sformatf("bb%0d_%0d_rdy", i, k), din_ready, 1'b1);
        @(posedge clk);
        #1;
        if (k == 3) begin
          chk($sformatf("bb%0d_dv", i), dout_valid, 1'b1);
          chk($sformatf("bb%0d_dout", i), dout, w);
        end else if (k == 0 && i > 0) begin
          chk($sformatf("bb%0d_dv0", i), dout_valid, 1'b0);
          chk($sformatf("bb%0d_wc", i), word_cnt, 32'(i));
        end
      end
    end
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("bb_wrap_wc", word_cnt, 8'd0);
    chk("bb_end_dv", dout_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dibit_pack.md
DIBIT_PACK -- requirements
Module: dibit_pack

Interface
REQ-001 Parameter: LSB_FIRST, default 1, slot k of a word lands in dout[2k+1:2k] when 1 and in dout[7-2k:6-2k] when 0.
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: din  input  2  dibit slice from the upstream 4:1 slice selector.
REQ-005 Port: din_valid  input  1  din carries a valid slice this cycle.
REQ-006 Port: din_first  input  1  qualifies din as slot 0 of a new word; sampled only on accepted beats.
REQ-007 Port: din_ready  output  1  block accepts a slice this cycle.
REQ-008 Port: dout  output  8  assembled word.
REQ-009 Port: dout_valid  output  1  dout holds an undelivered word.
REQ-010 Port: dout_ready  input  1  consumer takes dout this cycle.
REQ-011 Port: slot  output  2  index of the next slot to be filled, 0..3.
REQ-012 Port: sync_err  output  1  one-cycle pulse on a framing error.
REQ-013 Port: word_cnt  output  8  count of words delivered, wraps at 255->0.

Function
REQ-014 Accept beat = din_valid && din_ready on a rising clk edge; transfer = dout_valid && dout_ready on a rising clk edge.
REQ-015 The design is a 2-state FSM: FILL (assembling, slot 0..3) and HOLD (slot 3 filled and output register occupied, input stalled).
REQ-016 din_ready = 1 in FILL when slot != 3, or when slot == 3 and (!dout_valid || dout_ready); din_ready = 0 in HOLD; a combinational path from dout_ready to din_ready is permitted.
REQ-017 Each accepted beat writes din into the staging register at the position for the current slot (REQ-001), then slot increments modulo 4.
REQ-018 An accepted beat at slot 3 completes a word; the same edge loads staging plus that beat into dout, sets dout_valid, and returns slot to 0; latency from the 4th accepted beat to dout_valid is 1 cycle.
REQ-019 A transfer clears dout_valid and increments word_cnt modulo 256, unless the same edge also completes a new word; in that case dout_valid stays 1, dout takes the new word, and word_cnt still increments.
REQ-020 When din_first is 1 on an accepted beat with slot != 0, the partial word is discarded, the beat is stored as slot 0, slot becomes 1, and sync_err pulses high for exactly the next cycle.
REQ-021 When din_first is 1 on an accepted beat with slot == 0, the beat is normal and sync_err stays 0; din_first = 0 at slot 0 is legal.
REQ-022 dout stays stable while dout_valid = 1 and no transfer occurs; staging bits of unfilled slots are don't-care and never appear on dout.
REQ-023 The block makes no transition from HOLD to FILL except on a transfer; HOLD is entered only if din_ready logic is bypassed, so with REQ-016 the block never drops or overwrites an undelivered word.
REQ-024 Beats with din_valid = 0 change no state; din and din_first are ignored when din_valid = 0.

Reset
REQ-025 While rst_n = 0, all outputs and state clear asynchronously: FSM = FILL, slot = 0, staging = 0, dout = 8'h00, dout_valid = 0, sync_err = 0, word_cnt = 0; din_ready = 1 by REQ-016.
REQ-026 Reset asserted mid-word or with dout_valid = 1 discards all partial and held data, and no transfer is counted.
REQ-027 Deassertion of rst_n is synchronised to clk by the integrator; the block accepts a beat on the first rising edge after rst_n is high.

Verification
REQ-028 LSB_FIRST = 1, din = 11,01,10,01 on consecutive cycles with first = 1 on beat 0 and dout_ready = 1 -> dout = 8'h67, dout_valid high for 1 cycle, word_cnt = 1.
REQ-029 LSB_FIRST = 0, same four beats -> dout = 8'hD9.
REQ-030 dout_ready = 0 while two words (8'h67 then 8'hA5) are streamed -> din_ready drops at the 4th slice of word 2, dout holds 8'h67; raising dout_ready delivers 8'h67 then 8'hA5 with no loss, word_cnt = 2.
REQ-031 Two beats, then din_first = 1 with a full word 8'h3C -> sync_err pulses once, and dout = 8'h3C.
REQ-032 rst_n is pulsed low after two beats while a held word is pending -> all outputs read 0 immediately, and the next 4 beats yield the correct word.
REQ-033 256 back-to-back words with continuous ready -> a word every 4 cycles, and word_cnt wraps to 0.
